// File: rtl/fetch_pkg.sv
// Shared types for the fetch sequencer: FSM states and the single-entry response hold record.
// Latency: n/a (types only).
// Backpressure: n/a.
package fetch_pkg;
    localparam int XLEN_DEFAULT        = 32;
    localparam int FETCH_BYTES_DEFAULT = 8;
    localparam int HOLD_DATA_W         = 8 * FETCH_BYTES_DEFAULT;

    typedef enum logic [2:0] {
        BOOT,
        REQ,
        WAIT,
        STALL,
        SQUASH
    } fetch_state_e;

    typedef struct packed {
        logic [HOLD_DATA_W-1:0]  data;
        logic                    pred_taken;
        logic [XLEN_DEFAULT-1:0] pred_target;
    } fetch_hold_t;
endpackage

// File: rtl/fetch_hold_buf.sv
// Single-entry hold register for a fetch response that arrived while the fetch queue was full.
// Latency: loaded contents visible the cycle after load.
// Backpressure: none; the owner decides when to load and clear.
module fetch_hold_buf
    import fetch_pkg::*;
(
    input  logic        CLK,
    input  logic        reset,
    input  logic        load,
    input  logic        clear,
    input  fetch_hold_t din,
    output logic        valid,
    output fetch_hold_t dout
);

    always_ff @(posedge CLK) begin
        if (reset || clear) begin
            valid <= 1'b0;
            dout  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            dout  <= din;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns fetch PC, issues one block request at a time, forwards responses to the fetch queue.
// Latency: request the cycle after reset release; response forwarded combinationally in WAIT (2-cycle cadence).
// Backpressure: fq_full parks the response in a hold buffer (STALL); the request handshake holds the address until accepted.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int              XLEN        = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_PC    = '0,
    parameter int              FETCH_BYTES = FETCH_BYTES_DEFAULT
) (
    input  logic                     CLK,
    input  logic                     reset,
    input  logic                     mispredict,
    input  logic [XLEN-1:0]          actual_target_address,
    input  logic                     pred_taken,
    input  logic [XLEN-1:0]          pred_target,
    output logic                     ic_req_valid,
    input  logic                     ic_req_ready,
    output logic [XLEN-1:0]          ic_req_addr,
    input  logic                     ic_resp_valid,
    input  logic [8*FETCH_BYTES-1:0] ic_resp_data,
    input  logic                     fq_full,
    output logic                     fq_push,
    output logic [XLEN-1:0]          fq_pc,
    output logic [8*FETCH_BYTES-1:0] fq_data,
    output logic                     busy
);

    localparam int              DATA_W     = 8 * FETCH_BYTES;
    localparam logic [XLEN-1:0] STEP       = XLEN'(FETCH_BYTES);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(FETCH_BYTES - 1);

    fetch_state_e    state;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] aligned_pc;
    logic [XLEN-1:0] seq_pc;
    logic            resp_take;
    logic            resp_park;
    logic            stall_push;
    logic            hold_load;
    logic            hold_clear;
    logic            hold_vld;
    fetch_hold_t     hold_in;
    fetch_hold_t     hold_q;

    assign aligned_pc = fetch_pc & ALIGN_MASK;
    assign seq_pc     = aligned_pc + STEP;

    // mispredict kills any push or capture in the same cycle
    assign resp_take  = (state == WAIT)  && ic_resp_valid && !fq_full && !mispredict;
    assign resp_park  = (state == WAIT)  && ic_resp_valid &&  fq_full && !mispredict;
    assign stall_push = (state == STALL) && hold_vld      && !fq_full && !mispredict;

    assign hold_load  = resp_park;
    assign hold_clear = stall_push || ((state == STALL) && mispredict);

    always_comb begin
        hold_in             = '0;
        hold_in.data        = HOLD_DATA_W'(ic_resp_data);
        hold_in.pred_taken  = pred_taken;
        hold_in.pred_target = XLEN_DEFAULT'(pred_target);
    end

    fetch_hold_buf u_hold (
        .CLK   (CLK),
        .reset (reset),
        .load  (hold_load),
        .clear (hold_clear),
        .din   (hold_in),
        .valid (hold_vld),
        .dout  (hold_q)
    );

    assign ic_req_valid = (state == REQ);
    assign ic_req_addr  = ic_req_valid ? aligned_pc : '0;
    assign busy         = (state == WAIT) || (state == SQUASH);
    assign fq_push      = resp_take || stall_push;
    assign fq_pc        = fq_push ? fetch_pc : '0;
    assign fq_data      = resp_take  ? ic_resp_data :
                          stall_push ? DATA_W'(hold_q.data) : '0;

    always_ff @(posedge CLK) begin
        if (reset) begin
            state    <= BOOT;
            fetch_pc <= RESET_PC;
        end else if (state == BOOT) begin
            state <= REQ;
            if (mispredict) begin
                fetch_pc <= actual_target_address;
            end
        end else if (mispredict) begin
            fetch_pc <= actual_target_address;
            case (state)
                REQ:     state <= ic_req_ready  ? SQUASH : REQ;
                WAIT:    state <= ic_resp_valid ? REQ    : SQUASH;
                SQUASH:  state <= ic_resp_valid ? REQ    : SQUASH;
                default: state <= REQ;
            endcase
        end else begin
            case (state)
                REQ: begin
                    if (ic_req_ready) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (resp_take) begin
                        fetch_pc <= pred_taken ? pred_target : seq_pc;
                        state    <= REQ;
                    end else if (resp_park) begin
                        state <= STALL;
                    end
                end
                STALL: begin
                    if (stall_push) begin
                        fetch_pc <= hold_q.pred_taken ? XLEN'(hold_q.pred_target) : seq_pc;
                        state    <= REQ;
                    end else if (!hold_vld) begin
                        state <= REQ;
                    end
                end
                SQUASH: begin
                    if (ic_resp_valid) begin
                        state <= REQ;
                    end
                end
                default: state <= BOOT;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed vector bench for fetch_ctrl: per-cycle input/expected-output table plus a short cache-latency sequence.
module tb_fetch_ctrl;

    logic        CLK = 1'b0;
    logic        reset;
    logic        mispredict;
    logic [31:0] actual_target_address;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ic_req_valid;
    logic        ic_req_ready;
    logic [31:0] ic_req_addr;
    logic        ic_resp_valid;
    logic [63:0] ic_resp_data;
    logic        fq_full;
    logic        fq_push;
    logic [31:0] fq_pc;
    logic [63:0] fq_data;
    logic        busy;

    int nvec = 0;
    int nerr = 0;

    always #5 CLK = ~CLK;

    fetch_ctrl #(
        .XLEN        (32),
        .RESET_PC    (32'h100),
        .FETCH_BYTES (8)
    ) dut (
        .CLK                   (CLK),
        .reset                 (reset),
        .mispredict            (mispredict),
        .actual_target_address (actual_target_address),
        .pred_taken            (pred_taken),
        .pred_target           (pred_target),
        .ic_req_valid          (ic_req_valid),
        .ic_req_ready          (ic_req_ready),
        .ic_req_addr           (ic_req_addr),
        .ic_resp_valid         (ic_resp_valid),
        .ic_resp_data          (ic_resp_data),
        .fq_full               (fq_full),
        .fq_push               (fq_push),
        .fq_pc                 (fq_pc),
        .fq_data               (fq_data),
        .busy                  (busy)
    );

    // {ic_req_valid, ic_req_addr, fq_push, fq_pc, fq_data, busy}
    logic [130:0] outs;
    assign outs = {ic_req_valid, ic_req_addr, fq_push, fq_pc, fq_data, busy};

    typedef struct {
        logic        rst;
        logic        mp;
        logic [31:0] tgt;
        logic        pt;
        logic [31:0] ptgt;
        logic        rdy;
        logic        rv;
        logic [63:0] rd;
        logic        full;
        logic        e_vld;
        logic [31:0] e_addr;
        logic        e_push;
        logic [31:0] e_pc;
        logic [63:0] e_data;
        logic        e_busy;
    } vec_t;

    vec_t vecs[$];

    localparam logic [63:0] D1  = 64'h1111_0000_0000_0001;
    localparam logic [63:0] D2  = 64'h2222_0000_0000_0002;
    localparam logic [63:0] D3  = 64'hDEAD_BEEF_CAFE_F00D;
    localparam logic [63:0] D4  = 64'h4444_0000_0000_0004;
    localparam logic [63:0] D5  = 64'h5555_0000_0000_0005;
    localparam logic [63:0] D6  = 64'h6666_0000_0000_0006;
    localparam logic [63:0] D7  = 64'h7777_0000_0000_0007;
    localparam logic [63:0] D8  = 64'h8888_0000_0000_0008;
    localparam logic [63:0] D9  = 64'h9999_0000_0000_0009;
    localparam logic [63:0] D10 = 64'hAAAA_0000_0000_000A;
    localparam logic [63:0] D11 = 64'hBBBB_0000_0000_000B;
    localparam logic [63:0] D12 = 64'hCCCC_0000_0000_000C;
    localparam logic [63:0] D13 = 64'hDDDD_0000_0000_000D;

    function automatic vec_t mk(input logic rst, input logic mp, input logic [31:0] tgt,
                                input logic pt, input logic [31:0] ptgt, input logic rdy,
                                input logic rv, input logic [63:0] rd, input logic full,
                                input logic e_vld, input logic [31:0] e_addr, input logic e_push,
                                input logic [31:0] e_pc, input logic [63:0] e_data, input logic e_busy);
        vec_t t;
        t.rst = rst; t.mp = mp; t.tgt = tgt; t.pt = pt; t.ptgt = ptgt; t.rdy = rdy;
        t.rv = rv; t.rd = rd; t.full = full; t.e_vld = e_vld; t.e_addr = e_addr;
        t.e_push = e_push; t.e_pc = e_pc; t.e_data = e_data; t.e_busy = e_busy;
        return t;
    endfunction

    task automatic chk(input string name, input logic [130:0] act, input logic [130:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got vld=%b addr=%h push=%b pc=%h data=%h busy=%b, expected vld=%b addr=%h push=%b pc=%h data=%h busy=%b",
                     name, act[130], act[129:98], act[97], act[96:65], act[64:1], act[0],
                     exp[130], exp[129:98], exp[97], exp[96:65], exp[64:1], exp[0]);
        end
    endtask

    task automatic apply(input int idx, input vec_t t);
        @(negedge CLK);
        reset                 = t.rst;
        mispredict            = t.mp;
        actual_target_address = t.tgt;
        pred_taken            = t.pt;
        pred_target           = t.ptgt;
        ic_req_ready          = t.rdy;
        ic_resp_valid         = t.rv;
        ic_resp_data          = t.rd;
        fq_full               = t.full;
        #1;
        chk($sformatf("vec%0d", idx), outs,
            {t.e_vld, t.e_addr, t.e_push, t.e_pc, t.e_data, t.e_busy});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ea;
        logic [63:0] ed;

        reset = 1'b1; mispredict = 1'b0; actual_target_address = '0; pred_taken = 1'b0;
        pred_target = '0; ic_req_ready = 1'b0; ic_resp_valid = 1'b0; ic_resp_data = '0; fq_full = 1'b0;
        repeat (2) @(posedge CLK);

        //             rst mp tgt            pt ptgt        rdy rv rd   full  vld addr           push pc             data busy
        vecs.push_back(mk(1, 0, 0,             0, 0,          0, 0, 0,   0,    0, 0,             0, 0,             0,   0)); // reset state
        vecs.push_back(mk(0, 0, 0,             0, 0,          0, 0, 0,   0,    0, 0,             0, 0,             0,   0)); // BOOT
        vecs.push_back(mk(0, 0, 0,             0, 0,          1, 0, 0,   0,    1, 32'h100,       0, 0,             0,   0));
        vecs.push_back(mk(0, 0, 0,             0, 0,          0, 1, D1,  0,    0, 0,             1, 32'h100,       D1,  1));
        vecs.push_back(mk(0, 0, 0,             0, 0,          1, 0, 0,   0,    1, 32'h108,       0, 0,             0,   0));
        vecs.push_back(mk(0, 0, 0,             0, 0,          0, 1, D2,  0,    0, 0,             1, 32'h108,       D2,  1));
        vecs.push_back(mk(0, 0, 0,             0, 0,          1, 0, 0,   0,    1, 32'h110,       0, 0,             0,   0));
        vecs.push_back(mk(0, 0, 0,             1, 32'h2004,   0, 1, D3,  0,    0, 0,             1, 32'h110,       D3,  1)); // predicted taken
        vecs.push_back(mk(0, 0, 0,             0, 0,          1, 0, 0,   0,    1, 32'h2000,      0, 0,             0,   0));
        vecs.push_back(mk(0, 0, 0,             0, 0,          0, 1, D4,  0,    0, 0,             1, 32'h2004,      D4,  1));
        vecs.push_back(mk(0, 0, 0,             0, 0,          0, 0, 0,   0,    1, 32'h2008,      0, 0,             0,   0)); // not ready: hold addr
        vecs.push_back(mk(0, 0, 0,             0, 0,          1, 0, 0,   0,    1, 32'h2008,      0, 0,             0,   0));
        vecs.push_back(mk(0, 0, 0,             0, 0,          0, 0, 0,   0,    0, 0,             0, 0,             0,   1));
        vecs.push_back(mk(0, 0, 0,             1, 32'h3000,   0, 1, D5,  1,    0, 0,             0, 0,             0,   1)); // queue full
        vecs.push_back(mk(0, 0, 0,             0, 0,          0, 0, 0,   1,    0, 0,             0, 0,             0,   0));
        vecs.push_back(mk(0, 0, 0,             0, 0,          0, 0, 0,   1,    0, 0,             0, 0,             0,   0));
        vecs.push_back(mk(0, 0, 0,             0, 0,          0, 0, 0,   0,    0, 0,             1, 32'h2008,      D5,  0)); // held push
        vecs.push_back(mk(0, 0, 0,             0, 0,          1, 0, 0,   0,    1, 32'h3000,      0, 0,             0,   0));
        vecs.push_back(mk(0, 1, 32'h4000,      0, 0,          0, 0, 0,   0,    0, 0,             0, 0,             0,   1)); // mispredict in WAIT
        vecs.push_back(mk(0, 0, 0,             0, 0,          0, 0, 0,   0,    0, 0,             0, 0,             0,   1));
        vecs.push_back(mk(0, 0, 0,             0, 0,          0, 1, D6,  0,    0, 0,             0, 0,             0,   1)); // stale dropped
        vecs.push_back(mk(0, 0, 0,             0, 0,          1, 0, 0,   0,    1, 32'h4000,      0, 0,             0,   0));
        vecs.push_back(mk(0, 1, 32'h8000,      0, 0,          0, 1, D7,  0,    0, 0,             0, 0,             0,   1)); // mispredict with resp
        vecs.push_back(mk(0, 0, 0,             0, 0,          0, 0, 0,   0,    1, 32'h8000,      0, 0,             0,   0));
        vecs.push_back(mk(0, 1, 32'h9006,      0, 0,          1, 0, 0,   0,    1, 32'h8000,      0, 0,             0,   0)); // mispredict on accept
        vecs.push_back(mk(0, 1, 32'hA000,      0, 0,          0, 1, D8,  0,    0, 0,             0, 0,             0,   1)); // SQUASH + mp + resp
        vecs.push_back(mk(0, 0, 0,             0, 0,          1, 0, 0,   0,    1, 32'hA000,      0, 0,             0,   0));
        vecs.push_back(mk(0, 0, 0,             0, 0,          0, 1, D9,  1,    0, 0,             0, 0,             0,   1));
        vecs.push_back(mk(0, 1, 32'hB00C,      0, 0,          0, 0, 0,   0,    0, 0,             0, 0,             0,   0)); // mp in STALL
        vecs.push_back(mk(0, 0, 0,             0, 0,          1, 0, 0,   0,    1, 32'hB008,      0, 0,             0,   0));
        vecs.push_back(mk(0, 0, 0,             0, 0,          0, 1, D10, 0,    0, 0,             1, 32'hB00C,      D10, 1)); // unaligned pc kept
        vecs.push_back(mk(0, 1, 32'hFFFF_FFFA, 0, 0,          0, 0, 0,   0,    1, 32'hB010,      0, 0,             0,   0));
        vecs.push_back(mk(0, 0, 0,             0, 0,          1, 0, 0,   0,    1, 32'hFFFF_FFF8, 0, 0,             0,   0));
        vecs.push_back(mk(0, 0, 0,             0, 0,          0, 1, D11, 0,    0, 0,             1, 32'hFFFF_FFFA, D11, 1));
        vecs.push_back(mk(0, 0, 0,             0, 0,          1, 0, 0,   0,    1, 32'h0,         0, 0,             0,   0)); // wrapped
        vecs.push_back(mk(1, 0, 0,             0, 0,          0, 0, 0,   0,    0, 0,             0, 0,             0,   1)); // reset in WAIT
        vecs.push_back(mk(0, 0, 0,             0, 0,          0, 1, D12, 0,    0, 0,             0, 0,             0,   0)); // stale in BOOT
        vecs.push_back(mk(0, 0, 0,             0, 0,          0, 1, D12, 0,    1, 32'h100,       0, 0,             0,   0)); // stale in REQ
        vecs.push_back(mk(0, 0, 0,             0, 0,          1, 0, 0,   0,    1, 32'h100,       0, 0,             0,   0));
        vecs.push_back(mk(0, 0, 0,             0, 0,          0, 1, D13, 0,    0, 0,             1, 32'h100,       D13, 1));
        vecs.push_back(mk(1, 0, 0,             0, 0,          0, 0, 0,   0,    1, 32'h108,       0, 0,             0,   0));
        vecs.push_back(mk(0, 1, 32'h5000,      0, 0,          0, 0, 0,   0,    0, 0,             0, 0,             0,   0)); // mp in BOOT
        vecs.push_back(mk(0, 0, 0,             0, 0,          0, 0, 0,   0,    1, 32'h5000,      0, 0,             0,   0));

        foreach (vecs[i]) apply(i, vecs[i]);

        // variable response latency, with one block stalled behind a full queue
        ea = 32'h5000;
        for (int i = 0; i < 4; i++) begin
            ed = {ea, ~ea};
            @(negedge CLK);
            ic_resp_valid = 1'b0; fq_full = 1'b0; ic_req_ready = 1'b1;
            #1 chk("seq_req", outs, {1'b1, ea, 1'b0, 32'h0, 64'h0, 1'b0});
            @(negedge CLK);
            ic_req_ready = 1'b0;
            for (int k = 0; k < i; k++) begin
                #1 chk("seq_wait", outs, {1'b0, 32'h0, 1'b0, 32'h0, 64'h0, 1'b1});
                @(negedge CLK);
            end
            ic_resp_valid = 1'b1; ic_resp_data = ed; fq_full = (i == 2);
            if (i == 2) begin
                #1 chk("seq_park", outs, {1'b0, 32'h0, 1'b0, 32'h0, 64'h0, 1'b1});
                @(negedge CLK);
                ic_resp_valid = 1'b0; ic_resp_data = '0;
                #1 chk("seq_stall", outs, {1'b0, 32'h0, 1'b0, 32'h0, 64'h0, 1'b0});
                @(negedge CLK);
                fq_full = 1'b0;
                #1 chk("seq_unstall", outs, {1'b0, 32'h0, 1'b1, ea, ed, 1'b0});
            end else begin
                #1 chk("seq_resp", outs, {1'b0, 32'h0, 1'b1, ea, ed, 1'b1});
            end
            ea = ea + 32'h8;
        end
        @(negedge CLK);
        ic_resp_valid = 1'b0; fq_full = 1'b0;
        #1 chk("seq_final_req", outs, {1'b1, ea, 1'b0, 32'h0, 64'h0, 1'b0});

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
